// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module : acc_pkg
// Brief  : Shared types for the accelerator offload path (predecoder + offload stage).
// Rev    : 1.0
// ============================================================================
package acc_pkg;

    localparam int ACC_NUM_RSP    = 4;
    localparam int ACC_DATA_WIDTH = 32;
    localparam int ACC_ADDR_W     = (ACC_NUM_RSP > 1) ? $clog2(ACC_NUM_RSP) : 1;

    typedef struct packed {
        logic [31:0] q_instr_data;
    } acc_prd_req_t;

    typedef struct packed {
        logic       p_accept;
        logic [1:0] p_writeback;
        logic [2:0] p_use_rs;
    } acc_prd_rsp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECODE   = 2'd1,
        OPERANDS = 2'd2,
        ISSUE    = 2'd3
    } acc_offload_state_e;

    typedef struct packed {
        logic [ACC_ADDR_W-1:0]               addr;
        logic [31:0]                         instr_data;
        logic [2:0][ACC_DATA_WIDTH-1:0]      rs;
    } acc_offload_req_t;

endpackage
`default_nettype wire

// File: rtl/acc_prd_select.sv
`default_nettype none
// ============================================================================
// Module : acc_prd_select
// Brief  : Picks the lowest-index predecoder response with p_accept set.
// Rev    : 1.0
// ============================================================================
module acc_prd_select
    import acc_pkg::*;
#(
    parameter int NUM_RSP = ACC_NUM_RSP,
    parameter int IDX_W   = (NUM_RSP > 1) ? $clog2(NUM_RSP) : 1
) (
    input  acc_prd_rsp_t [NUM_RSP-1:0] i_rsp,
    output logic                       o_hit,
    output logic [IDX_W-1:0]           o_index,
    output acc_prd_rsp_t               o_rsp
);

    // Scan from the top down so the lowest accepting index is written last.
    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
        o_rsp   = '0;
        for (int i = NUM_RSP - 1; i >= 0; i--) begin
            if (i_rsp[i].p_accept) begin
                o_hit   = 1'b1;
                o_index = IDX_W'(i);
                o_rsp   = i_rsp[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/acc_offload_stage.sv
`default_nettype none
// ============================================================================
// Module : acc_offload_stage
// Brief  : Broadcasts a core instruction to predecoders, gathers operands and
//          issues the routed request; bounds in-flight writebacks.
// Rev    : 1.0
// ============================================================================
module acc_offload_stage
    import acc_pkg::*;
#(
    parameter int NUM_RSP         = ACC_NUM_RSP,
    parameter int DATA_WIDTH      = ACC_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = (NUM_RSP > 1) ? $clog2(NUM_RSP) : 1,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        core_req_valid_i,
    output logic                        core_req_ready_o,
    input  logic [31:0]                 core_instr_i,
    input  logic [3*DATA_WIDTH-1:0]     core_rs_i,
    input  logic [2:0]                  core_rs_valid_i,
    output logic                        core_ack_valid_o,
    output logic                        core_ack_accept_o,
    output logic [1:0]                  core_ack_writeback_o,
    output acc_prd_req_t                prd_req_o,
    input  acc_prd_rsp_t [NUM_RSP-1:0]  prd_rsp_i,
    output logic                        acc_req_valid_o,
    input  logic                        acc_req_ready_i,
    output logic [ADDR_W-1:0]           acc_req_addr_o,
    output logic [31:0]                 acc_req_instr_o,
    output logic [3*DATA_WIDTH-1:0]     acc_req_rs_o,
    input  logic                        wb_done_i,
    output logic [CNT_W-1:0]            outstanding_o
);

    localparam logic [CNT_W-1:0] C_MAX_OUT = CNT_W'(MAX_OUTSTANDING);

    acc_offload_state_e r_state;
    acc_offload_req_t   r_req;
    acc_prd_req_t       r_prd_req;
    logic [1:0]         r_wb;
    logic [2:0]         r_use;
    logic [2:0]         r_got;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_hit;
    logic [ADDR_W-1:0]  w_sel_idx;
    acc_prd_rsp_t       w_sel_rsp;
    logic               w_accept;
    logic               w_hs;
    logic [2:0]         w_cap;
    logic               w_ops_done;
    logic               w_inc;
    logic               w_dec;

    acc_prd_select #(
        .NUM_RSP (NUM_RSP),
        .IDX_W   (ADDR_W)
    ) u_select (
        .i_rsp   (prd_rsp_i),
        .o_hit   (w_hit),
        .o_index (w_sel_idx),
        .o_rsp   (w_sel_rsp)
    );

    assign w_accept   = w_hit & w_sel_rsp.p_accept;
    assign w_hs       = (r_state == ISSUE) & acc_req_ready_i;
    assign w_cap      = (r_state == OPERANDS) ? (r_use & ~r_got & core_rs_valid_i) : 3'b000;
    assign w_ops_done = (((r_got | w_cap) & r_use) == r_use);
    assign w_inc      = w_hs & (r_wb != 2'b00);
    assign w_dec      = wb_done_i & (r_cnt != '0);

    // Ready depends only on state and count, never on the interconnect ready.
    assign core_req_ready_o     = (r_state == IDLE) & (r_cnt < C_MAX_OUT);
    assign core_ack_valid_o     = ((r_state == DECODE) & ~w_accept) | w_hs;
    assign core_ack_accept_o    = w_hs;
    assign core_ack_writeback_o = w_hs ? r_wb : 2'b00;
    assign prd_req_o            = r_prd_req;
    assign acc_req_valid_o      = (r_state == ISSUE);
    assign acc_req_addr_o       = r_req.addr;
    assign acc_req_instr_o      = r_req.instr_data;
    assign acc_req_rs_o         = r_req.rs;
    assign outstanding_o        = r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_prd_req <= '0;
            r_wb      <= 2'b00;
            r_use     <= 3'b000;
            r_got     <= 3'b000;
        end else begin
            r_prd_req <= '0;
            case (r_state)
                IDLE: begin
                    if (core_req_valid_i && core_req_ready_o) begin
                        r_req.instr_data       <= core_instr_i;
                        r_prd_req.q_instr_data <= core_instr_i;
                        r_state                <= DECODE;
                    end
                end
                DECODE: begin
                    if (w_accept) begin
                        r_req.addr <= w_sel_idx;
                        r_req.rs   <= '0;
                        r_wb       <= w_sel_rsp.p_writeback;
                        r_use      <= w_sel_rsp.p_use_rs;
                        r_got      <= 3'b000;
                        r_state    <= OPERANDS;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                OPERANDS: begin
                    for (int i = 0; i < 3; i++) begin
                        if (w_cap[i]) begin
                            r_req.rs[i] <= core_rs_i[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    r_got <= r_got | w_cap;
                    if (w_ops_done) begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (acc_req_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (!w_inc && w_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // A writeback completion with nothing in flight indicates a protocol error upstream.
    a_wb_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(wb_done_i && (r_cnt == '0)));

endmodule
`default_nettype wire

// File: tb/tb_acc_offload_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_acc_offload_stage
// Brief  : Self-checking bench for acc_offload_stage against a transaction model.
// Rev    : 1.0
// ============================================================================
module tb_acc_offload_stage;
    import acc_pkg::*;

    localparam int DW   = ACC_DATA_WIDTH;
    localparam int NR   = 4;
    localparam int MAXO = 2;
    localparam int AW   = 2;
    localparam int CW   = 2;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                core_req_valid_i;
    logic                core_req_ready_o;
    logic [31:0]         core_instr_i;
    logic [3*DW-1:0]     core_rs_i;
    logic [2:0]          core_rs_valid_i;
    logic                core_ack_valid_o;
    logic                core_ack_accept_o;
    logic [1:0]          core_ack_writeback_o;
    acc_prd_req_t        prd_req_o;
    acc_prd_rsp_t [NR-1:0] prd_rsp;
    logic                acc_req_valid_o;
    logic                acc_req_ready_i;
    logic [AW-1:0]       acc_req_addr_o;
    logic [31:0]         acc_req_instr_o;
    logic [3*DW-1:0]     acc_req_rs_o;
    logic                wb_done_i;
    logic [CW-1:0]       outstanding_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_m = 0;
    bit en_wb = 1'b0;

    always #5 clk = ~clk;

    acc_offload_stage #(
        .NUM_RSP         (NR),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .core_req_valid_i     (core_req_valid_i),
        .core_req_ready_o     (core_req_ready_o),
        .core_instr_i         (core_instr_i),
        .core_rs_i            (core_rs_i),
        .core_rs_valid_i      (core_rs_valid_i),
        .core_ack_valid_o     (core_ack_valid_o),
        .core_ack_accept_o    (core_ack_accept_o),
        .core_ack_writeback_o (core_ack_writeback_o),
        .prd_req_o            (prd_req_o),
        .prd_rsp_i            (prd_rsp),
        .acc_req_valid_o      (acc_req_valid_o),
        .acc_req_ready_i      (acc_req_ready_i),
        .acc_req_addr_o       (acc_req_addr_o),
        .acc_req_instr_o      (acc_req_instr_o),
        .acc_req_rs_o         (acc_req_rs_o),
        .wb_done_i            (wb_done_i),
        .outstanding_o        (outstanding_o)
    );

    // Predecoder r claims an instruction when bit 8+r is set; its writeback is instr[13:12]^r.
    always_comb begin
        prd_rsp = '0;
        for (int r = 0; r < NR; r++) begin
            prd_rsp[r].p_accept    = prd_req_o.q_instr_data[8+r];
            prd_rsp[r].p_writeback = prd_req_o.q_instr_data[13:12] ^ 2'(r);
            prd_rsp[r].p_use_rs    = prd_req_o.q_instr_data[18:16];
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input bit inc);
        @(posedge clk);
        if (rst_i) cnt_m = 0;
        else       cnt_m = cnt_m + int'(inc) - ((wb_done_i && cnt_m > 0) ? 1 : 0);
        @(negedge clk);
        check_eq("outstanding", outstanding_o, cnt_m);
        wb_done_i = en_wb && (cnt_m > 0) && ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_txn(input logic [31:0] instr, input int d0, input int d1, input int d2,
                          input int dr, input bit wb_hs, input int rst_at);
        int              d[3];
        logic [DW-1:0]   val[3];
        bit              acc;
        bit              ok;
        int              addr;
        logic [1:0]      wb;
        logic [2:0]      use_rs;
        int              maxd;
        logic [3*DW-1:0] exp_rs;
        d = '{d0, d1, d2};

        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            check_eq("idle_ready", core_req_ready_o, cnt_m < MAXO);
            check_eq("idle_req_valid", acc_req_valid_o, 1'b0);
            check_eq("idle_ack", core_ack_valid_o, 1'b0);
            if (cnt_m < MAXO) begin
                ok = 1'b1;
                break;
            end
            step(1'b0);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got 0 expected 1");
            return;
        end

        core_req_valid_i = 1'b1;
        core_instr_i     = instr;
        step(1'b0);
        core_req_valid_i = 1'b0;
        core_instr_i     = $urandom;

        acc    = |instr[11:8];
        addr   = 0;
        for (int r = NR - 1; r >= 0; r--) if (instr[8+r]) addr = r;
        wb     = instr[13:12] ^ 2'(addr);
        use_rs = instr[18:16];
        check_eq("dec_prd_req", prd_req_o, instr);
        check_eq("dec_ack_valid", core_ack_valid_o, !acc);
        check_eq("dec_ack_accept", core_ack_accept_o, 1'b0);
        check_eq("dec_ack_wb", core_ack_writeback_o, 2'b00);
        core_rs_valid_i = 3'($urandom);
        core_rs_i       = {$urandom, $urandom, $urandom};

        if (!acc) begin
            step(1'b0);
            check_eq("rej_ready", core_req_ready_o, cnt_m < MAXO);
            check_eq("rej_ack", core_ack_valid_o, 1'b0);
            check_eq("rej_req_valid", acc_req_valid_o, 1'b0);
            return;
        end

        maxd = 0;
        for (int i = 0; i < 3; i++) begin
            if (use_rs[i] && d[i] > maxd) maxd = d[i];
            val[i] = DW'($urandom);
            exp_rs[i*DW +: DW] = use_rs[i] ? val[i] : '0;
        end
        step(1'b0);

        for (int k = 0; k <= maxd; k++) begin
            check_eq("opr_req_valid", acc_req_valid_o, 1'b0);
            check_eq("opr_ack", core_ack_valid_o, 1'b0);
            check_eq("opr_prd_req", prd_req_o, 32'h0);
            for (int i = 0; i < 3; i++) begin
                if (use_rs[i]) begin
                    core_rs_valid_i[i]  = (k >= d[i]);
                    core_rs_i[i*DW +: DW] = (k == d[i]) ? val[i] : DW'($urandom);
                end else begin
                    core_rs_valid_i[i]  = 1'($urandom);
                    core_rs_i[i*DW +: DW] = DW'($urandom);
                end
            end
            step(1'b0);
        end

        for (int j = 0; j <= dr; j++) begin
            core_rs_valid_i = 3'($urandom);
            core_rs_i       = {$urandom, $urandom, $urandom};
            if (j == rst_at) begin
                acc_req_ready_i = 1'b0;
                wb_done_i       = 1'b0;
                rst_i           = 1'b1;
                step(1'b0);
                rst_i = 1'b0;
                #1;
                check_eq("rst_req_valid", acc_req_valid_o, 1'b0);
                check_eq("rst_ack", core_ack_valid_o, 1'b0);
                check_eq("rst_ack_accept", core_ack_accept_o, 1'b0);
                check_eq("rst_addr", acc_req_addr_o, '0);
                check_eq("rst_instr", acc_req_instr_o, 32'h0);
                check_eq("rst_rs", acc_req_rs_o, '0);
                check_eq("rst_prd_req", prd_req_o, 32'h0);
                check_eq("rst_ready", core_req_ready_o, 1'b1);
                return;
            end
            acc_req_ready_i = (j == dr);
            if (j == dr && wb_hs && cnt_m > 0) wb_done_i = 1'b1;
            #1;
            check_eq("iss_valid", acc_req_valid_o, 1'b1);
            check_eq("iss_addr", acc_req_addr_o, addr);
            check_eq("iss_instr", acc_req_instr_o, instr);
            check_eq("iss_rs", acc_req_rs_o, exp_rs);
            check_eq("iss_ack_valid", core_ack_valid_o, j == dr);
            check_eq("iss_ack_accept", core_ack_accept_o, j == dr);
            check_eq("iss_ack_wb", core_ack_writeback_o, (j == dr) ? wb : 2'b00);
            check_eq("iss_ready_low", core_req_ready_o, 1'b0);
            step((j == dr) && (wb != 2'b00));
        end
        acc_req_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] instr;
        rst_i            = 1'b1;
        core_req_valid_i = 1'b0;
        core_instr_i     = '0;
        core_rs_i        = '0;
        core_rs_valid_i  = '0;
        acc_req_ready_i  = 1'b0;
        wb_done_i        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        check_eq("reset_ready", core_req_ready_o, 1'b1);
        check_eq("reset_req_valid", acc_req_valid_o, 1'b0);
        check_eq("reset_ack", core_ack_valid_o, 1'b0);
        check_eq("reset_outstanding", outstanding_o, 0);
        check_eq("reset_prd_req", prd_req_o, 32'h0);

        do_txn(32'h0000_007B, 0, 0, 0, 0, 1'b0, -1);   // nobody accepts
        do_txn(32'h0000_340B, 0, 0, 0, 0, 1'b0, -1);   // responder 2, wb=01, no operands
        do_txn(32'h0003_1A2B, 0, 3, 0, 0, 1'b0, -1);   // responders 1 and 3, rs2 late, wb=00

        while (cnt_m > 0) begin
            wb_done_i = 1'b1;
            step(1'b0);
        end

        // Saturate with two writeback-producing issues under backpressure.
        do_txn(32'h0007_215B, 0, 0, 0, 5, 1'b0, -1);
        do_txn(32'h0007_215B, 1, 0, 2, 5, 1'b0, -1);
        for (int t = 0; t < 3; t++) begin
            check_eq("sat_ready", core_req_ready_o, 1'b0);
            step(1'b0);
        end
        wb_done_i = 1'b1;
        step(1'b0);
        check_eq("sat_release", core_req_ready_o, 1'b1);
        do_txn(32'h0007_215B, 0, 0, 0, 1, 1'b1, -1);   // issue coincides with wb_done
        do_txn(32'h0005_2C00, 0, 1, 0, 6, 1'b0, 2);    // reset while requesting

        en_wb = 1'b1;
        for (int n = 0; n < 40; n++) begin
            instr = $urandom;
            if ($urandom_range(0, 3) == 0) instr[11:8] = 4'h0;
            do_txn(instr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/acc_offload_stage.md
Name: acc_offload_stage

Overview:
- Core-side offload stage directly upstream of the accelerator predecoders.
- Accepts one offloaded instruction from the core and broadcasts it to NumRsp predecoders. Selects the accepting responder, collects the source operands it requests, then issues a routed request to the accelerator interconnect.
- Reports accept/reject and expected writeback back to the core.
- Tracks outstanding writebacks to bound in-flight instructions.

Parameters:
- NumRsp, 4, number of predecoders/responders queried in parallel (>=1).
- DataWidth, 32, width of each source operand.
- MaxOutstanding, 4, maximum issued instructions still awaiting writeback (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- core_req_valid_i  in  1  core offers instruction
- core_req_ready_o  out  1  stage accepts instruction
- core_instr_i  in  32  instruction word
- core_rs_i  in  3*DataWidth  source operands rs1..rs3
- core_rs_valid_i  in  3  per-operand valid from core forwarding/scoreboard
- core_ack_valid_o  out  1  single-cycle decision pulse
- core_ack_accept_o  out  1  1=offloaded, 0=rejected (illegal instr)
- core_ack_writeback_o  out  2  p_writeback of the accepting responder
- prd_req_o  out  acc_prd_req_t  broadcast to all predecoders
- prd_rsp_i  in  NumRsp*acc_prd_rsp_t  predecoder responses (combinational from prd_req_o)
- acc_req_valid_o  out  1  request to interconnect
- acc_req_ready_i  in  1  interconnect ready
- acc_req_addr_o  out  max(1,$clog2(NumRsp))  index of target responder
- acc_req_instr_o  out  32  instruction
- acc_req_rs_o  out  3*DataWidth  latched operands; unused operands driven 0
- wb_done_i  in  1  one writeback completed
- outstanding_o  out  $clog2(MaxOutstanding+1)  in-flight count

Behaviour:
- FSM states: IDLE, DECODE, OPERANDS, ISSUE.
- Reset (synchronous, any state):
  - Return to IDLE, clear outstanding count, drop any held instruction.
  - All outputs 0, except core_req_ready_o, which is 1 in the first cycle after reset.
- IDLE:
  - core_req_ready_o = (outstanding < MaxOutstanding).
  - On valid&ready, latch core_instr_i and go to DECODE.
  - core_instr_i is sampled only on this handshake.
- DECODE (exactly 1 cycle):
  - prd_req_o.q_instr_data = latched instr; prd_req_o is 0 in all other states.
  - Select the lowest-index responder with p_accept=1 and latch its index, p_writeback and p_use_rs.
  - If no responder accepts: core_ack_valid_o=1, accept=0, writeback=0 this cycle; go to IDLE.
  - If one or more accept: go to OPERANDS. Multiple acceptors is legal; lowest index wins.
- OPERANDS:
  - Each cycle, for every operand i with use_rs[i]=1, capture core_rs_i[i] on the first cycle its core_rs_valid_i[i]=1.
  - Stay in OPERANDS until all required operands are captured.
  - Transition to ISSUE on the cycle after the final capture.
  - If use_rs=0, still spend one cycle in OPERANDS.
- ISSUE:
  - acc_req_valid_o=1; addr/instr/rs held stable until acc_req_ready_i.
  - On the handshake cycle: core_ack_valid_o=1, accept=1, writeback=latched value.
  - outstanding increments if writeback != 0; go to IDLE.
- Latency: request handshake in cycle N gives DECODE at N+1, OPERANDS at N+2, and acc_req_valid_o at N+3 at the earliest.
- Outstanding counter:
  - Increment on an ISSUE handshake with writeback != 0; decrement on wb_done_i.
  - Simultaneous increment and decrement leaves the count unchanged.
  - wb_done_i at count 0 is ignored and flagged by an assertion.
  - At count = MaxOutstanding, IDLE holds core_req_ready_o=0 until a decrement.
- No combinational path from acc_req_ready_i to core_req_ready_o.

Decomposition:
- Add to acc_pkg:
  - acc_offload_state_e enum (IDLE/DECODE/OPERANDS/ISSUE).
  - acc_offload_req_t struct {addr, instr_data, rs[3]} parameterised through localparams.
  - Existing acc_prd_req_t/acc_prd_rsp_t unchanged.
- One sub-module: acc_prd_select — combinational lowest-index accept selector over NumRsp responses. Outputs: hit, index, selected acc_prd_rsp_t.

Test Plan:
- Reject: instr 0x0000_007B, no responder accepts -> core_ack_valid_o pulse at N+1 with accept=0; acc_req_valid_o never asserts; ready again at N+2.
- Single accept, no operands: responder 2 accepts with writeback=2'b01, use_rs=0 -> acc_req_valid_o at N+3 with addr=2, rs all 0; ack accept=1, writeback=01 on handshake; outstanding_o=1.
- Multiple accept plus late operand: responders 1 and 3 accept with use_rs=3'b011; rs2 valid 3 cycles late -> addr=1; issue delayed 3 cycles; rs1/rs2 carry the captured values, rs3=0.
- Backpressure plus saturation: MaxOutstanding=2, acc_req_ready_i low 5 cycles -> request and payload held stable. After 2 writeback issues, core_req_ready_o=0 until wb_done_i; simultaneous issue+wb_done_i keeps the count constant.
- Reset mid-ISSUE: rst_i asserted while acc_req_valid_o=1 -> next cycle all outputs 0, outstanding_o=0, FSM in IDLE, no ack pulse.
